// File: rtl/serdiv_sc_miter_chk.sv
// Two-run non-interference miter around a fixed-latency serial divider.
// Optional SERDIV_MITER_SNAPSHOT_EN adds snap_res_o1/snap_res_o2 captures.
module serdiv_sc #(
  parameter int WIDTH         = 64,
  parameter int TRANS_ID_BITS = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [TRANS_ID_BITS-1:0] id_i,
  input  logic [WIDTH-1:0]         op_a_i,
  input  logic [WIDTH-1:0]         op_b_i,
  input  logic                     op_a_label_i,
  input  logic                     op_b_label_i,
  input  logic [1:0]               opcode_i,
  input  logic                     in_vld_i,
  output logic                     in_rdy_o,
  input  logic                     flush_i,
  output logic                     out_vld_o,
  input  logic                     out_rdy_i,
  output logic [TRANS_ID_BITS-1:0] id_o,
  output logic [WIDTH-1:0]         res_o,
  output logic                     res_label_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, DIV, DONE} st_t;

  st_t                     st;
  logic [WIDTH-1:0]        rem;
  logic [WIDTH-1:0]        quo;
  logic [WIDTH-1:0]        dvs;
  logic [WIDTH-1:0]        res;
  logic [CW-1:0]           cnt;
  logic                    neg_q;
  logic                    neg_r;
  logic                    rem_op;
  logic                    lab;
  logic [TRANS_ID_BITS-1:0] id;

  logic             sa;
  logic             sb;
  logic             b_zero;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  always_comb begin
    sa     = opcode_i[0] & op_a_i[WIDTH-1];
    sb     = opcode_i[0] & op_b_i[WIDTH-1];
    b_zero = (op_b_i == '0);
    abs_a  = sa ? -op_a_i : op_a_i;
    abs_b  = sb ? -op_b_i : op_b_i;
    sh     = {rem, quo[WIDTH-1]};
    diff   = sh - {1'b0, dvs};
    ge     = ~diff[WIDTH];
    rem_n  = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
    quo_n  = {quo[WIDTH-2:0], ge};
    q_fin  = neg_q ? -quo_n : quo_n;
    r_fin  = neg_r ? -rem_n : rem_n;
  end

  // Every division runs exactly WIDTH steps, independent of operand values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st     <= IDLE;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      res    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      rem_op <= 1'b0;
      lab    <= 1'b0;
      id     <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (in_vld_i) begin
            st     <= DIV;
            quo    <= abs_a;
            rem    <= '0;
            dvs    <= abs_b;
            cnt    <= CW'(WIDTH - 1);
            neg_q  <= (sa ^ sb) & ~b_zero;
            neg_r  <= sa;
            rem_op <= opcode_i[1];
            id     <= id_i;
            lab    <= op_a_label_i | op_b_label_i;
          end
        end
        DIV: begin
          quo <= quo_n;
          rem <= rem_n;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            st  <= DONE;
            res <= rem_op ? r_fin : q_fin;
          end
        end
        DONE: begin
          if (out_rdy_i) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
      if (flush_i) st <= IDLE;
    end
  end

  assign in_rdy_o    = (st == IDLE);
  assign out_vld_o   = (st == DONE);
  assign id_o        = id;
  assign res_o       = res;
  assign res_label_o = lab;
endmodule

module serdiv_sc_miter_chk #(
  parameter int WIDTH         = 64,
  parameter int CNT_W         = 16,
  parameter int TRANS_ID_BITS = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [TRANS_ID_BITS-1:0] id_i,
  input  logic [WIDTH-1:0]         op_a_i1,
  input  logic [WIDTH-1:0]         op_a_i2,
  input  logic [WIDTH-1:0]         op_b_i1,
  input  logic [WIDTH-1:0]         op_b_i2,
  input  logic [1:0]               opcode_i,
  input  logic                     in_vld_i,
  input  logic                     flush_i,
  input  logic                     out_rdy_i,
  input  logic                     op_a_label_i,
  input  logic                     op_b_label_i,
  output logic [1:0]               in_rdy_o,
  output logic [1:0]               out_vld_o,
  output logic [1:0]               res_label_o,
  output logic [WIDTH-1:0]         res_o1,
  output logic [WIDTH-1:0]         res_o2,
  output logic                     leak_o,
  output logic [2:0]               leak_kind_o,
  output logic [CNT_W-1:0]         leak_cycle_o,
  output logic                     assume_ok_o
`ifdef SERDIV_MITER_SNAPSHOT_EN
  ,
  output logic [WIDTH-1:0]         snap_res_o1,
  output logic [WIDTH-1:0]         snap_res_o2
`endif
);
  typedef enum logic [1:0] {ARMED, LEAK, VOID} st_t;

  logic                     u1_rdy, u2_rdy;
  logic                     u1_vld, u2_vld;
  logic                     u1_lab, u2_lab;
  logic [WIDTH-1:0]         u1_res, u2_res;
  logic [TRANS_ID_BITS-1:0] u1_id, u2_id;

  serdiv_sc #(.WIDTH(WIDTH), .TRANS_ID_BITS(TRANS_ID_BITS)) u1 (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .id_i         (id_i),
    .op_a_i       (op_a_i1),
    .op_b_i       (op_b_i1),
    .op_a_label_i (op_a_label_i),
    .op_b_label_i (op_b_label_i),
    .opcode_i     (opcode_i),
    .in_vld_i     (in_vld_i),
    .in_rdy_o     (u1_rdy),
    .flush_i      (flush_i),
    .out_vld_o    (u1_vld),
    .out_rdy_i    (out_rdy_i),
    .id_o         (u1_id),
    .res_o        (u1_res),
    .res_label_o  (u1_lab)
  );

  serdiv_sc #(.WIDTH(WIDTH), .TRANS_ID_BITS(TRANS_ID_BITS)) u2 (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .id_i         (id_i),
    .op_a_i       (op_a_i2),
    .op_b_i       (op_b_i2),
    .op_a_label_i (op_a_label_i),
    .op_b_label_i (op_b_label_i),
    .opcode_i     (opcode_i),
    .in_vld_i     (in_vld_i),
    .in_rdy_o     (u2_rdy),
    .flush_i      (flush_i),
    .out_vld_o    (u2_vld),
    .out_rdy_i    (out_rdy_i),
    .id_o         (u2_id),
    .res_o        (u2_res),
    .res_label_o  (u2_lab)
  );

  assign in_rdy_o    = {u2_rdy, u1_rdy};
  assign out_vld_o   = {u2_vld, u1_vld};
  assign res_label_o = {u2_lab, u1_lab};
  assign res_o1      = u1_res;
  assign res_o2      = u2_res;

  logic       viol;
  logic       both_vld;
  logic [2:0] kind;

  always_comb begin
    viol = in_vld_i &
           ((~op_a_label_i & (op_a_i1 != op_a_i2)) |
            (~op_b_label_i & (op_b_i1 != op_b_i2)));
    both_vld = u1_vld & u2_vld;
    kind[0]  = (u1_rdy != u2_rdy) | (u1_vld != u2_vld);
    kind[1]  = both_vld & (u1_lab != u2_lab);
    kind[2]  = both_vld & ~u1_lab & ~u2_lab &
               ((u1_res != u2_res) | (u1_id != u2_id));
  end

  st_t              st;
  logic [CNT_W-1:0] cnt;

  // An assumption violation voids the run even if a divergence coincides.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st           <= ARMED;
      cnt          <= '0;
      leak_o       <= 1'b0;
      leak_kind_o  <= '0;
      leak_cycle_o <= '0;
      assume_ok_o  <= 1'b1;
`ifdef SERDIV_MITER_SNAPSHOT_EN
      snap_res_o1  <= '0;
      snap_res_o2  <= '0;
`endif
    end else begin
      if (cnt != '1) cnt <= cnt + 1'b1;
      unique case (st)
        ARMED: begin
          if (viol) begin
            st          <= VOID;
            assume_ok_o <= 1'b0;
          end else if (kind != '0) begin
            st           <= LEAK;
            leak_o       <= 1'b1;
            leak_kind_o  <= kind;
            leak_cycle_o <= cnt;
`ifdef SERDIV_MITER_SNAPSHOT_EN
            snap_res_o1  <= u1_res;
            snap_res_o2  <= u2_res;
`endif
          end
        end
        LEAK: st <= LEAK;
        VOID: st <= VOID;
        default: st <= ARMED;
      endcase
    end
  end
endmodule

// File: tb/tb_serdiv_sc_miter_chk.sv
// Directed bench for serdiv_sc_miter_chk (WIDTH=8; CNT_W=8 and CNT_W=4).
// Divergences are injected by forcing U2 outputs inside the miter.
module tb_serdiv_sc_miter_chk;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] id;
  logic [7:0] a1, a2, b1, b2;
  logic [1:0] op;
  logic       in_vld, flush, out_rdy, la, lb;

  logic [1:0] in_rdy, out_vld, res_lab;
  logic [7:0] res1, res2;
  logic       leak, ok;
  logic [2:0] kind;
  logic [7:0] lcyc;

  logic [1:0] in_rdy4, out_vld4, res_lab4;
  logic [7:0] res14, res24;
  logic       leak4, ok4;
  logic [2:0] kind4;
  logic [3:0] lcyc4;

  int n_chk  = 0;
  int n_fail = 0;
  int now    = 0;

  always #5 clk = ~clk;

  serdiv_sc_miter_chk #(.WIDTH(8), .CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .id_i(id),
    .op_a_i1(a1), .op_a_i2(a2), .op_b_i1(b1), .op_b_i2(b2),
    .opcode_i(op), .in_vld_i(in_vld), .flush_i(flush),
    .out_rdy_i(out_rdy), .op_a_label_i(la), .op_b_label_i(lb),
    .in_rdy_o(in_rdy), .out_vld_o(out_vld), .res_label_o(res_lab),
    .res_o1(res1), .res_o2(res2), .leak_o(leak),
    .leak_kind_o(kind), .leak_cycle_o(lcyc), .assume_ok_o(ok)
  );

  serdiv_sc_miter_chk #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .id_i(id),
    .op_a_i1(a1), .op_a_i2(a2), .op_b_i1(b1), .op_b_i2(b2),
    .opcode_i(op), .in_vld_i(in_vld), .flush_i(flush),
    .out_rdy_i(out_rdy), .op_a_label_i(la), .op_b_label_i(lb),
    .in_rdy_o(in_rdy4), .out_vld_o(out_vld4), .res_label_o(res_lab4),
    .res_o1(res14), .res_o2(res24), .leak_o(leak4),
    .leak_kind_o(kind4), .leak_cycle_o(lcyc4), .assume_ok_o(ok4)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    now++;
  endtask

  task automatic go_to(input int k);
    while (now < k) tick();
  endtask

  task automatic reset_dut();
    rst_n  = 1'b0;
    in_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    now   = 0;
  endtask

  task automatic set_ops(input logic [1:0] o, input logic [7:0] x1,
                         input logic [7:0] x2, input logic [7:0] y1,
                         input logic [7:0] y2, input logic sa,
                         input logic sb);
    op = o; a1 = x1; a2 = x2; b1 = y1; b2 = y2; la = sa; lb = sb;
  endtask

  task automatic issue();
    in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
  endtask

  task automatic wait_vld(input string tag);
    for (int i = 0; i < 40 && out_vld[0] !== 1'b1; i++) tick();
    chk(tag, 64'(out_vld), 64'(2'b11));
  endtask

  task automatic div_chk(input string tag, input logic [1:0] o,
                         input logic [7:0] x1, input logic [7:0] x2,
                         input logic [7:0] y, input logic sa,
                         input logic [7:0] e1, input logic [7:0] e2,
                         input logic [1:0] elab);
    set_ops(o, x1, x2, y, y, sa, 1'b0);
    issue();
    wait_vld({tag, "_vld"});
    chk({tag, "_r1"}, 64'(res1), 64'(e1));
    chk({tag, "_r2"}, 64'(res2), 64'(e2));
    chk({tag, "_lab"}, 64'(res_lab), 64'(elab));
    tick();
  endtask

  initial begin
    id = 4'h5; flush = 1'b0; out_rdy = 1'b1;
    set_ops(2'b00, 8'd0, 8'd0, 8'd1, 8'd1, 1'b0, 1'b0);
    reset_dut();
    chk("rst_leak", 64'(leak), 64'd0);
    chk("rst_ok", 64'(ok), 64'd1);
    chk("rst_kind", 64'(kind), 64'd0);
    chk("rst_cyc", 64'(lcyc), 64'd0);
    chk("rst_rdy", 64'(in_rdy), 64'(2'b11));
    chk("rst_vld", 64'(out_vld), 64'd0);

    div_chk("div", 2'b01, 8'd100, 8'd100, 8'd7, 1'b0, 8'd14, 8'd14, 2'b00);
    div_chk("rem", 2'b11, 8'd100, 8'd100, 8'd7, 1'b0, 8'd2, 8'd2, 2'b00);
    div_chk("udiv", 2'b00, 8'd200, 8'd200, 8'd7, 1'b0, 8'd28, 8'd28, 2'b00);
    div_chk("sdivn", 2'b01, 8'd156, 8'd156, 8'd7, 1'b0, 8'd242, 8'd242, 2'b00);
    div_chk("sremn", 2'b11, 8'd156, 8'd156, 8'd7, 1'b0, 8'd254, 8'd254, 2'b00);
    div_chk("div0", 2'b00, 8'd100, 8'd100, 8'd0, 1'b0, 8'd255, 8'd255, 2'b00);
    div_chk("rem0", 2'b10, 8'd100, 8'd100, 8'd0, 1'b0, 8'd100, 8'd100, 2'b00);
    div_chk("ovf", 2'b01, 8'd128, 8'd128, 8'd255, 1'b0, 8'd128, 8'd128, 2'b00);
    div_chk("sec", 2'b01, 8'd100, 8'd3, 8'd7, 1'b1, 8'd14, 8'd0, 2'b11);
    chk("a_leak", 64'(leak), 64'd0);
    chk("a_ok", 64'(ok), 64'd1);

    // Assumption violation at cycle 10, later divergence is ignored.
    reset_dut();
    set_ops(2'b01, 8'd5, 8'd6, 8'd7, 8'd7, 1'b0, 1'b0);
    go_to(10);
    issue();
    chk("v_ok", 64'(ok), 64'd0);
    chk("v_leak", 64'(leak), 64'd0);
    go_to(50);
    force dut.u2_vld = 1'b1;
    tick();
    release dut.u2_vld;
    go_to(111);
    chk("v_leak100", 64'(leak), 64'd0);
    chk("v_ok100", 64'(ok), 64'd0);

    // Timing divergence at cycle 20.
    reset_dut();
    go_to(20);
    chk("t_pre", 64'(leak), 64'd0);
    force dut.u2_vld = 1'b1;
    tick();
    release dut.u2_vld;
    chk("t_leak", 64'(leak), 64'd1);
    chk("t_kind", 64'(kind), 64'(3'b001));
    chk("t_cyc", 64'(lcyc), 64'd20);
    chk("t_ok", 64'(ok), 64'd1);

    // Violation and divergence together: violation wins.
    reset_dut();
    set_ops(2'b01, 8'd5, 8'd6, 8'd7, 8'd7, 1'b0, 1'b0);
    go_to(5);
    force dut.u2_vld = 1'b1;
    issue();
    release dut.u2_vld;
    chk("vt_leak", 64'(leak), 64'd0);
    chk("vt_ok", 64'(ok), 64'd0);
    chk("vt_kind", 64'(kind), 64'd0);

    // Data divergence.
    reset_dut();
    set_ops(2'b01, 8'd100, 8'd100, 8'd7, 8'd7, 1'b0, 1'b0);
    issue();
    wait_vld("d_vld");
    force dut.u2_res = 8'h0f;
    tick();
    release dut.u2_res;
    chk("d_leak", 64'(leak), 64'd1);
    chk("d_kind", 64'(kind), 64'(3'b100));

    // Label and timing divergence in the same cycle.
    reset_dut();
    issue();
    wait_vld("lt_vld");
    force dut.u2_lab = 1'b1;
    force dut.u2_rdy = 1'b1;
    tick();
    release dut.u2_lab;
    release dut.u2_rdy;
    chk("lt_leak", 64'(leak), 64'd1);
    chk("lt_kind", 64'(kind), 64'(3'b011));

    // Saturating 4-bit counter, then reset and restart.
    reset_dut();
    go_to(18);
    force dut4.u2_vld = 1'b1;
    tick();
    release dut4.u2_vld;
    chk("s_leak", 64'(leak4), 64'd1);
    chk("s_cyc", 64'(lcyc4), 64'd15);
    chk("s_kind", 64'(kind4), 64'(3'b001));
    go_to(29);
    rst_n = 1'b0;
    tick();
    chk("s_rleak", 64'(leak4), 64'd0);
    chk("s_rok", 64'(ok4), 64'd1);
    chk("s_rcyc", 64'(lcyc4), 64'd0);
    rst_n = 1'b1;
    now   = 0;
    go_to(3);
    force dut4.u2_vld = 1'b1;
    tick();
    release dut4.u2_vld;
    chk("s_leak2", 64'(leak4), 64'd1);
    chk("s_cyc2", 64'(lcyc4), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
